// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 4:1 MUX. It steps the selects through 00..11, holds each
// value for HOLD_CYCLES clocks, samples f, and reports all four samples with a done strobe.
module mux_scan_sequencer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       f_in,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       done,
  output logic [3:0] result
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t           state;
  logic [1:0]       sel;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       shadow;

  assign s0 = sel[0];
  assign s1 = sel[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= 2'b00;
      cnt    <= '0;
      shadow <= 3'b000;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 4'b0000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sel  <= 2'b00;
          busy <= 1'b0;
          if (start) begin
            state <= DRIVE;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == LAST) begin
            cnt <= '0;
            case (sel)
              2'd0:    shadow[0] <= f_in;
              2'd1:    shadow[1] <= f_in;
              2'd2:    shadow[2] <= f_in;
              default: ;
            endcase
            // The last channel goes straight into result so done and data line up.
            if (sel != 2'd3) begin
              sel <= sel + 2'd1;
            end else begin
              state  <= DONE;
              result <= {f_in, shadow};
              done   <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          sel <= 2'b00;
          cnt <= '0;
          if (cont) begin
            state <= DRIVE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          sel   <= 2'b00;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer. Two instances are used: HOLD_CYCLES=4, with f driven by a MUX model,
// and HOLD_CYCLES=1, with f driven directly. Each instance is checked against a cycle-count model.
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic       rst4_n, start4, cont4, f_in4, s0_4, s1_4, busy4, done4;
  logic [3:0] result4, mux4;
  logic       rst1_n, start1, cont1, f_in1, s0_1, s1_1, busy1, done1;
  logic [3:0] result1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mux_scan_sequencer #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .start(start4), .cont(cont4), .f_in(f_in4),
    .s0(s0_4), .s1(s1_4), .busy(busy4), .done(done4), .result(result4)
  );

  mux_scan_sequencer #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .cont(cont1), .f_in(f_in1),
    .s0(s0_1), .s1(s1_1), .busy(busy1), .done(done1), .result(result1)
  );

  // MUX model: mux4 bit k is the value of input k (a=0 .. d=3).
  assign f_in4 = mux4[{s1_4, s0_4}];

  always @(posedge clk) cyc <= cyc + 1;

  // Model state: t counts edges since the start edge. Samples land at every multiple of the hold time.
  int       hold[2] = '{4, 1};
  bit       act[2];
  int       t[2];
  bit [3:0] samp[2];
  bit [3:0] res[2];

  task automatic modelStep(input int i, input bit r, input bit st, input bit ct, input bit fi);
    int h;
    h = hold[i];
    if (!r) begin
      act[i] = 1'b0;
      t[i] = 0;
      res[i] = 4'b0000;
    end else if (!act[i]) begin
      if (st) begin
        act[i] = 1'b1;
        t[i] = 0;
      end
    end else if (t[i] == 4 * h) begin
      if (ct) t[i] = 0;
      else act[i] = 1'b0;
    end else begin
      if ((t[i] + 1) % h == 0) samp[i][(t[i] + 1) / h - 1] = fi;
      t[i] = t[i] + 1;
      if (t[i] == 4 * h) res[i] = samp[i];
    end
  endtask

  function automatic logic [31:0] expSel(input int i);
    if (!act[i]) return 0;
    if (t[i] >= 4 * hold[i]) return 3;
    return t[i] / hold[i];
  endfunction

  always @(posedge clk) begin
    modelStep(0, rst4_n, start4, cont4, f_in4);
    modelStep(1, rst1_n, start1, cont1, f_in1);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("sel4", {30'd0, s1_4, s0_4}, expSel(0));
    checkOutput("busy4", {31'd0, busy4}, {31'd0, act[0]});
    checkOutput("done4", {31'd0, done4}, {31'd0, act[0] && t[0] == 4 * hold[0]});
    checkOutput("result4", {28'd0, result4}, {28'd0, res[0]});
    checkOutput("sel1", {30'd0, s1_1, s0_1}, expSel(1));
    checkOutput("busy1", {31'd0, busy1}, {31'd0, act[1]});
    checkOutput("done1", {31'd0, done1}, {31'd0, act[1] && t[1] == 4 * hold[1]});
    checkOutput("result1", {28'd0, result1}, {28'd0, res[1]});
  end

  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitForDone(input int budget, output int when);
    when = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        when = cyc;
        break;
      end
    end
    if (when < 0) checkOutput("done4_timeout", 0, 1);
  endtask

  task automatic countDones(input int cycles, output int count);
    count = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (done4 === 1'b1) count++;
    end
  endtask

  int s, d, d1, d2, d3, nd;

  initial begin
    $display("[TB] starting");
    rst4_n = 1'b0; rst1_n = 1'b0; start4 = 1'b1; start1 = 1'b1;
    cont4 = 1'b0; cont1 = 1'b0; mux4 = 4'b1111; f_in1 = 1'b1;
    applyStimulus(3);
    checkOutput("t1_busy", busy4, 0);
    checkOutput("t1_done", done4, 0);
    checkOutput("t1_sel", {s1_4, s0_4}, 0);
    checkOutput("t1_result", result4, 0);
    rst4_n = 1'b1; rst1_n = 1'b1; start4 = 1'b0; start1 = 1'b0;
    applyStimulus(3);
    checkOutput("t1_nostart", busy4, 0);

    // Single scan with a=1, b=0, c=1, d=1.
    mux4 = 4'b1101; start4 = 1'b1; applyStimulus(1); start4 = 1'b0; s = cyc;
    waitForDone(40, d);
    checkOutput("t2_latency", d - s, 16);
    checkOutput("t2_result", result4, 4'b1101);
    applyStimulus(1);
    checkOutput("t2_idle_busy", busy4, 0);
    checkOutput("t2_idle_sel", {s1_4, s0_4}, 0);

    // start pulses while busy must be ignored.
    start4 = 1'b1; applyStimulus(1); start4 = 1'b0; s = cyc;
    while (cyc - s < 4) applyStimulus(1);
    start4 = 1'b1; applyStimulus(1); start4 = 1'b0;
    while (cyc - s < 14) applyStimulus(1);
    start4 = 1'b1; applyStimulus(1); start4 = 1'b0;
    waitForDone(10, d);
    checkOutput("t3_latency", d - s, 16);
    countDones(20, nd);
    checkOutput("t3_extra_done", nd, 0);

    // Continuous mode. The inputs change before scan 2 samples, and cont drops during scan 3.
    mux4 = 4'b0110; cont4 = 1'b1; start4 = 1'b1; applyStimulus(1); start4 = 1'b0; s = cyc;
    waitForDone(40, d1);
    checkOutput("t4_latency", d1 - s, 16);
    checkOutput("t4_result1", result4, 4'b0110);
    mux4 = 4'b1001;
    waitForDone(40, d2);
    checkOutput("t4_period2", d2 - d1, 17);
    checkOutput("t4_result2", result4, 4'b1001);
    applyStimulus(3); cont4 = 1'b0;
    waitForDone(40, d3);
    checkOutput("t4_period3", d3 - d2, 17);
    countDones(30, nd);
    checkOutput("t4_stops", nd, 0);
    checkOutput("t4_idle_busy", busy4, 0);

    // Reset in the middle of a scan aborts the scan.
    mux4 = 4'b0101; start4 = 1'b1; applyStimulus(1); start4 = 1'b0; s = cyc;
    while (cyc - s < 8) applyStimulus(1);
    rst4_n = 1'b0; applyStimulus(1); rst4_n = 1'b1;
    checkOutput("t5_busy", busy4, 0);
    checkOutput("t5_result", result4, 0);
    countDones(40, nd);
    checkOutput("t5_no_done", nd, 0);
    start4 = 1'b1; applyStimulus(1); start4 = 1'b0; s = cyc;
    waitForDone(40, d);
    checkOutput("t5_latency", d - s, 16);
    checkOutput("t5_result2", result4, 4'b0101);

    // HOLD_CYCLES=1 takes one sample per clock.
    start1 = 1'b1; applyStimulus(1); start1 = 1'b0;
    f_in1 = 1'b1; applyStimulus(1);
    f_in1 = 1'b1; applyStimulus(1);
    f_in1 = 1'b0; applyStimulus(1);
    f_in1 = 1'b1; applyStimulus(1);
    checkOutput("t6_done", done1, 1);
    checkOutput("t6_result", result1, 4'b1011);
    applyStimulus(2);
    checkOutput("t6_idle", busy1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
